mcu_bus_fabric: RTL and testbench

- Parametrised single-master, multi-slave memory bus between the CPU core and N memory-mapped targets (memory controller, peripherals).
- Replaces the point-to-point CPU-to-memory hookup.
- Adds address decode, a per-slave select, a ready handshake with wait-state support, a bus timeout, and decode/slave error reporting back to the CPU.

---
 rtl/mcu_bus_fabric.sv | 158 +++++++++++++++
 tb/tb_mcu_bus_fabric.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mcu_bus_fabric.sv
// Single-master bus fabric: address decode, one-hot slave select, wait states, timeout, error return.
// Latency: request edge -> strobe next cycle -> m_ready one cycle after slave ready; master holds request until m_ready.
module mcu_bus_fabric #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int NUM_SLV = 4,
   // slave i base/mask live at bits [i*ADDR_W +: ADDR_W]
   parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = {32'h3000_0000, 32'h2000_0000,
                                                    32'h1000_0000, 32'h0000_0000},
   parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = {4{32'hF000_0000}},
   parameter int TIMEOUT = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [ADDR_W-1:0]           m_addr,
   input  logic [DATA_W-1:0]           m_wdata,
   input  logic                        m_read,
   input  logic                        m_write,
   output logic [DATA_W-1:0]           m_rdata,
   output logic                        m_ready,
   output logic                        m_error,
   output logic [NUM_SLV-1:0]          s_sel,
   output logic [ADDR_W-1:0]           s_addr,
   output logic [DATA_W-1:0]           s_wdata,
   output logic                        s_read,
   output logic                        s_write,
   input  logic [NUM_SLV*DATA_W-1:0]   s_rdata,
   input  logic [NUM_SLV-1:0]          s_ready,
   input  logic [NUM_SLV-1:0]          s_error
);

   localparam int            CW       = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t              state, state_nxt;
   logic [CW-1:0]       cnt, cnt_nxt;
   logic [NUM_SLV-1:0]  sel_nxt, hit, hit_1h;
   logic [ADDR_W-1:0]   addr_nxt;
   logic [DATA_W-1:0]   wdata_nxt, rdata_nxt, sel_rdata;
   logic                rd_nxt, wr_nxt, ready_nxt, error_nxt;
   logic                sel_rdy, sel_err;

   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         hit[i] = (m_addr & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
                  (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W]);
      end
   end

   // isolate the lowest set bit so the lowest-index slave wins on overlap
   assign hit_1h = hit & (~hit + NUM_SLV'(1));

   assign sel_rdy = |(s_ready & s_sel);
   assign sel_err = |(s_error & s_sel);

   always_comb begin
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (s_sel[i]) sel_rdata = sel_rdata | s_rdata[i*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      sel_nxt   = s_sel;
      addr_nxt  = s_addr;
      wdata_nxt = s_wdata;
      rd_nxt    = s_read;
      wr_nxt    = s_write;
      rdata_nxt = m_rdata;
      ready_nxt = 1'b0;
      error_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (m_read ^ m_write) begin
               addr_nxt  = m_addr;
               wdata_nxt = m_wdata;
               cnt_nxt   = '0;
               if (|hit) begin
                  state_nxt = ACCESS;
                  sel_nxt   = hit_1h;
                  rd_nxt    = m_read;
                  wr_nxt    = m_write;
               end else begin
                  state_nxt = RESP;
                  ready_nxt = 1'b1;
                  error_nxt = 1'b1;
                  rdata_nxt = '0;
               end
            end else if (m_read && m_write) begin
               state_nxt = RESP;
               ready_nxt = 1'b1;
               error_nxt = 1'b1;
               rdata_nxt = '0;
            end
         end
         ACCESS: begin
            // ready is checked before expiry so a last-cycle ready still completes cleanly
            if (sel_rdy) begin
               state_nxt = RESP;
               ready_nxt = 1'b1;
               error_nxt = sel_err;
               rdata_nxt = s_read ? sel_rdata : '0;
               sel_nxt   = '0;
               rd_nxt    = 1'b0;
               wr_nxt    = 1'b0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = RESP;
               ready_nxt = 1'b1;
               error_nxt = 1'b1;
               rdata_nxt = '0;
               sel_nxt   = '0;
               rd_nxt    = 1'b0;
               wr_nxt    = 1'b0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         s_sel   <= '0;
         s_addr  <= '0;
         s_wdata <= '0;
         s_read  <= 1'b0;
         s_write <= 1'b0;
         m_rdata <= '0;
         m_ready <= 1'b0;
         m_error <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         s_sel   <= sel_nxt;
         s_addr  <= addr_nxt;
         s_wdata <= wdata_nxt;
         s_read  <= rd_nxt;
         s_write <= wr_nxt;
         m_rdata <= rdata_nxt;
         m_ready <= ready_nxt;
         m_error <= error_nxt;
      end
   end

endmodule

// File: tb/tb_mcu_bus_fabric.sv
// Directed bench for mcu_bus_fabric: inputs driven and outputs sampled on the falling edge.
module tb_mcu_bus_fabric;

   logic         clk;
   logic         rst;
   logic [31:0]  m_addr, m_wdata, m_rdata;
   logic         m_read, m_write, m_ready, m_error;
   logic [3:0]   s_sel;
   logic [31:0]  s_addr, s_wdata;
   logic         s_read, s_write;
   logic [127:0] s_rdata;
   logic [3:0]   s_ready, s_error;

   int n_chk  = 0;
   int n_pass = 0;
   int cnt;
   int cyc;
   logic [31:0] rd;
   logic        er;

   mcu_bus_fabric dut (
      .clk     (clk),
      .rst     (rst),
      .m_addr  (m_addr),
      .m_wdata (m_wdata),
      .m_read  (m_read),
      .m_write (m_write),
      .m_rdata (m_rdata),
      .m_ready (m_ready),
      .m_error (m_error),
      .s_sel   (s_sel),
      .s_addr  (s_addr),
      .s_wdata (s_wdata),
      .s_read  (s_read),
      .s_write (s_write),
      .s_rdata (s_rdata),
      .s_ready (s_ready),
      .s_error (s_error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // drives one request from a falling edge, waits (bounded) for m_ready, then idles one cycle
   task automatic xfer(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rdo, output logic erro, output int ncyc);
      m_read = r; m_write = w; m_addr = a; m_wdata = d;
      ncyc = 0;
      do begin
         @(negedge clk);
         ncyc++;
      end while (!m_ready && ncyc < 40);
      rdo  = m_rdata;
      erro = m_error;
      m_read = 1'b0; m_write = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b0;
      m_addr = '0; m_wdata = '0; m_read = 1'b0; m_write = 1'b0;
      s_rdata = '0; s_ready = '0; s_error = '0;
      repeat (2) @(negedge clk);
      chk("rst_m_ready", m_ready, 0);
      chk("rst_m_rdata", m_rdata, 0);
      chk("rst_s_sel",   s_sel, 0);
      chk("rst_strobes", {s_read, s_write, m_error}, 0);
      rst = 1'b1;
      @(negedge clk);

      // 1: zero-wait read from slave1, then back-to-back restart
      m_read = 1'b1; m_addr = 32'h1000_0004;
      s_ready = 4'b0010; s_rdata[32 +: 32] = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("t1_s_sel",   s_sel, 4'b0010);
      chk("t1_s_read",  s_read, 1);
      chk("t1_s_addr",  s_addr, 32'h1000_0004);
      chk("t1_early_rdy", m_ready, 0);
      @(negedge clk);
      chk("t1_m_ready", m_ready, 1);
      chk("t1_m_rdata", m_rdata, 32'hDEAD_BEEF);
      chk("t1_m_error", m_error, 0);
      chk("t1_strobe_drop", {s_read, s_sel}, 0);
      @(negedge clk);
      chk("t1_pulse_1cyc", m_ready, 0);
      chk("t1_rdata_hold", m_rdata, 32'hDEAD_BEEF);
      @(negedge clk);
      chk("t1_b2b_read", s_read, 1);
      m_read = 1'b0;
      repeat (2) @(negedge clk);

      // 2: write to slave2 with three wait states
      m_write = 1'b1; m_addr = 32'h2000_0010; m_wdata = 32'h1234_5678;
      s_ready = '0; s_rdata[64 +: 32] = 32'hFFFF_FFFF;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (s_write && s_sel == 4'b0100 && s_wdata == 32'h1234_5678 && !m_ready) cnt++;
      end
      s_ready = 4'b0100;
      chk("t2_wr_hold", cnt, 4);
      @(negedge clk);
      chk("t2_m_ready", m_ready, 1);
      chk("t2_m_error", m_error, 0);
      chk("t2_m_rdata", m_rdata, 0);
      chk("t2_s_write_drop", s_write, 0);
      m_write = 1'b0; s_ready = '0;
      @(negedge clk);

      // 3: unmapped address
      s_ready = 4'b1111;
      xfer(1'b1, 1'b0, 32'h5000_0000, 32'h0, rd, er, cyc);
      chk("t3_latency", cyc, 1);
      chk("t3_error", er, 1);
      chk("t3_rdata", rd, 0);

      // 4: timeout on slave3 while other slaves sit ready
      m_read = 1'b1; m_addr = 32'h3000_0000; s_ready = 4'b0111;
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (s_read && s_sel == 4'b1000 && !m_ready) cnt++;
      end
      chk("t4_access_cycles", cnt, 16);
      @(negedge clk);
      chk("t4_m_ready", m_ready, 1);
      chk("t4_m_error", m_error, 1);
      chk("t4_strobe_drop", {s_read, s_sel}, 0);
      m_read = 1'b0; s_ready = '0;
      @(negedge clk);
      s_ready = 4'b0001; s_rdata[0 +: 32] = 32'hA5A5_0001;
      xfer(1'b1, 1'b0, 32'h0000_0100, 32'h0, rd, er, cyc);
      chk("t4_next_latency", cyc, 2);
      chk("t4_next_rdata", rd, 32'hA5A5_0001);
      chk("t4_next_error", er, 0);

      // 5: slave error, then illegal read+write
      s_ready = 4'b0001; s_error = 4'b0001;
      xfer(1'b1, 1'b0, 32'h0000_0040, 32'h0, rd, er, cyc);
      chk("t5_slv_err", er, 1);
      chk("t5_slv_latency", cyc, 2);
      s_error = '0; s_ready = 4'b1111;
      m_read = 1'b1; m_write = 1'b1; m_addr = 32'h1000_0000;
      @(negedge clk);
      chk("t5_ill_ready", m_ready, 1);
      chk("t5_ill_error", m_error, 1);
      chk("t5_ill_no_sel", {s_sel, s_read, s_write}, 0);
      m_read = 1'b0; m_write = 1'b0;
      @(negedge clk);

      // ready arriving in the final allowed wait cycle wins over timeout
      m_read = 1'b1; m_addr = 32'h3000_0000; s_ready = '0;
      s_rdata[96 +: 32] = 32'h3333_3333;
      repeat (16) @(negedge clk);
      s_ready = 4'b1000;
      @(negedge clk);
      chk("edge_ready", m_ready, 1);
      chk("edge_error", m_error, 0);
      chk("edge_rdata", m_rdata, 32'h3333_3333);
      m_read = 1'b0; s_ready = '0;
      @(negedge clk);

      // 6: asynchronous reset in the middle of a wait
      m_write = 1'b1; m_addr = 32'h2000_0000; m_wdata = 32'h0000_55AA;
      repeat (3) @(negedge clk);
      chk("t6_pre_write", s_write, 1);
      #2 rst = 1'b0;
      #1;
      chk("t6_async_strobe", {s_write, s_read, s_sel}, 0);
      chk("t6_async_addr", s_addr, 0);
      chk("t6_async_wdata", s_wdata, 0);
      chk("t6_async_rdata", m_rdata, 0);
      m_write = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1; s_ready = 4'b1111;
      cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (m_ready) cnt++;
      end
      chk("t6_no_resp", cnt, 0);
      s_rdata[32 +: 32] = 32'h0BAD_F00D;
      xfer(1'b1, 1'b0, 32'h1000_0000, 32'h0, rd, er, cyc);
      chk("t6_idle_latency", cyc, 2);
      chk("t6_idle_rdata", rd, 32'h0BAD_F00D);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
